i2c_ball_slave: RTL and testbench

//  I2C slave receiver on the opposite board of the ball-handoff link. Samples open-drain SCL/SDA

---
 rtl/i2c_ball_slave.sv | 186 ++++++++++++++++++
 tb/tb_i2c_ball_slave.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_ball_slave.sv
// I2C write-only slave that receives one 3-byte ball packet {ball_y[9:0], ball_vy[7:0]}.
// Latency: pin edges are seen 3 clk late; committed outputs update 1 clk after STOP is detected.
// Backpressure: none; the slave never stretches SCL and only ACKs/NACKs on SDA.
module i2c_ball_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SCL,
  inout  wire        SDA,
  output logic [9:0] ball_y,
  output logic [7:0] ball_vy,
  output logic       rx_valid,
  output logic       is_receiving,
  output logic [15:0] led
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_ADDR     = 4'd1,
    S_ADDR_ACK = 4'd2,
    S_DATA     = 4'd3,
    S_DATA_ACK = 4'd4,
    S_IGNORE   = 4'd5
  } state_t;

  // Synchroniser and history flops; bus idles high so they reset to 1.
  logic scl_s1_q, scl_s2_q, scl_h_q;
  logic sda_s1_q, sda_s2_q, sda_h_q;

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        ack_q, ack_d;       // slave currently pulling SDA low
  logic        is_rx_q, is_rx_d;
  logic [1:0]  d0_q, d0_d;
  logic [7:0]  d1_q, d1_d;
  logic [7:0]  d2_q, d2_d;
  logic [9:0]  ball_y_q;
  logic [7:0]  ball_vy_q;
  logic        rx_valid_q;
  logic        commit;

  logic scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] shift_next;

  assign scl_rise   = scl_s2_q & ~scl_h_q;
  assign scl_fall   = ~scl_s2_q & scl_h_q;
  assign start_det  = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
  assign stop_det   = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;
  assign shift_next = {shift_q[6:0], sda_s2_q};

  // Open-drain drive; reset releases the line combinationally so it never lingers a cycle.
  assign SDA = (ack_q && !reset) ? 1'b0 : 1'bz;

  assign ball_y       = ball_y_q;
  assign ball_vy      = ball_vy_q;
  assign rx_valid     = rx_valid_q;
  assign is_receiving = is_rx_q;
  assign led          = {state_q, byte_cnt_q, shift_q};

  // Pin synchronisation and edge history.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      scl_h_q  <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
      sda_h_q  <= 1'b1;
    end else begin
      scl_s1_q <= SCL;
      scl_s2_q <= scl_s1_q;
      scl_h_q  <= scl_s2_q;
      sda_s1_q <= SDA;
      sda_s2_q <= sda_s1_q;
      sda_h_q  <= sda_s2_q;
    end
  end

  // Next-state logic: START/STOP override every state, otherwise byte framing and ACK timing.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    ack_d      = ack_q;
    is_rx_d    = is_rx_q;
    d0_d       = d0_q;
    d1_d       = d1_q;
    d2_d       = d2_q;
    commit     = 1'b0;
    if (start_det) begin
      state_d    = S_ADDR;
      bit_cnt_d  = 3'd0;
      byte_cnt_d = 4'd0;
      ack_d      = 1'b0;
      is_rx_d    = 1'b0;
    end else if (stop_det) begin
      state_d = S_IDLE;
      ack_d   = 1'b0;
      is_rx_d = 1'b0;
      commit  = (byte_cnt_q == 4'd3);
    end else begin
      case (state_q)
        S_ADDR: begin
          if (scl_rise) begin
            shift_d = shift_next;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d = 3'd0;
              state_d   = (shift_next == {SLAVE_ADDR, 1'b0}) ? S_ADDR_ACK : S_IGNORE;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end
        S_ADDR_ACK, S_DATA_ACK: begin
          // First falling edge (end of bit 8) starts the ACK, second (end of ACK clock) ends it.
          if (scl_fall) begin
            if (!ack_q) begin
              ack_d   = 1'b1;
              is_rx_d = 1'b1;
            end else begin
              ack_d   = 1'b0;
              state_d = S_DATA;
            end
          end
        end
        S_DATA: begin
          if (scl_rise) begin
            shift_d = shift_next;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d  = 3'd0;
              byte_cnt_d = byte_cnt_q + 4'd1;
              case (byte_cnt_q)
                4'd0:    d0_d = shift_next[1:0];
                4'd1:    d1_d = shift_next;
                4'd2:    d2_d = shift_next;
                default: ;
              endcase
              state_d = (byte_cnt_q < 4'd3) ? S_DATA_ACK : S_IGNORE;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State, datapath and committed output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= 4'd0;
      shift_q    <= 8'd0;
      ack_q      <= 1'b0;
      is_rx_q    <= 1'b0;
      d0_q       <= 2'd0;
      d1_q       <= 8'd0;
      d2_q       <= 8'd0;
      ball_y_q   <= 10'd0;
      ball_vy_q  <= 8'd0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      ack_q      <= ack_d;
      is_rx_q    <= is_rx_d;
      d0_q       <= d0_d;
      d1_q       <= d1_d;
      d2_q       <= d2_d;
      rx_valid_q <= commit;
      if (commit) begin
        ball_y_q  <= {d0_q, d1_q};
        ball_vy_q <= d2_q;
      end
    end
  end

endmodule

// File: tb/tb_i2c_ball_slave.sv
// Bit-banged I2C master driving the ball slave, checked against a packet-level reference model.
// Latency: each SCL quarter period is Q system clocks.
// Backpressure: none; ACKs are sampled mid-high on the ninth clock of each byte.
module tb_i2c_ball_slave;

  localparam int Q = 25;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl;
  logic       m_sda_low;
  wire        SDA;
  logic [9:0] ball_y;
  logic [7:0] ball_vy;
  logic       rx_valid;
  logic       is_receiving;
  logic [15:0] led;

  pullup (SDA);
  assign SDA = m_sda_low ? 1'b0 : 1'bz;

  i2c_ball_slave #(.SLAVE_ADDR(7'h12)) dut (
    .clk(clk), .reset(reset), .SCL(scl), .SDA(SDA),
    .ball_y(ball_y), .ball_vy(ball_vy), .rx_valid(rx_valid),
    .is_receiving(is_receiving), .led(led)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int rx_cnt = 0;      // clock cycles with rx_valid high
  int slave_low = 0;   // cycles the slave alone pulls SDA low

  always @(negedge clk) begin
    if (rx_valid === 1'b1) rx_cnt++;
    if (!m_sda_low && SDA === 1'b0) slave_low++;
  end

  // Reference model state
  logic [7:0] tx_q[$];
  bit         ack_q[$];
  logic [9:0] exp_y  = 10'd0;
  logic [7:0] exp_vy = 8'd0;

  function automatic bit exp_ack(input int idx);
    return (tx_q[0] == 8'h24) && (idx <= 3);
  endfunction

  // Returns 1 when the packet in tx_q should commit, and updates the expected outputs.
  function automatic int model_commit(input bit with_stop);
    if (with_stop && tx_q.size() == 4 && tx_q[0] == 8'h24) begin
      exp_y  = {tx_q[1][1:0], tx_q[2]};
      exp_vy = tx_q[3];
      return 1;
    end
    return 0;
  endfunction

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_cond();
    if (scl == 1'b0) begin
      m_sda_low = 1'b0; wq(Q);
      scl = 1'b1; wq(Q);
    end
    m_sda_low = 1'b1; wq(Q);
    scl = 1'b0; wq(Q);
  endtask

  task automatic stop_cond();
    m_sda_low = 1'b1; wq(Q);
    scl = 1'b1; wq(Q);
    m_sda_low = 1'b0; wq(2 * Q);
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      m_sda_low = ~b[i]; wq(Q);
      scl = 1'b1; wq(2 * Q);
      scl = 1'b0; wq(Q);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output bit acked);
    send_bits(b);
    m_sda_low = 1'b0; wq(Q);
    scl = 1'b1; wq(Q);
    acked = (SDA === 1'b0);
    wq(Q);
    scl = 1'b0; wq(Q);
  endtask

  task automatic run_packet(input bit with_stop);
    bit a;
    ack_q.delete();
    start_cond();
    foreach (tx_q[i]) begin
      send_byte(tx_q[i], a);
      ack_q.push_back(a);
    end
    if (with_stop) stop_cond();
  endtask

  task automatic test_reset();
    reset = 1'b1; scl = 1'b1; m_sda_low = 1'b0;
    wq(5);
    total++;
    if ({ball_y, ball_vy} !== 18'd0) begin bad++; $display("FAIL reset_ball: got %0h want 0", {ball_y, ball_vy}); end
    total++;
    if ({rx_valid, is_receiving} !== 2'b00) begin bad++; $display("FAIL reset_flags: got %b want 00", {rx_valid, is_receiving}); end
    total++;
    if (led !== 16'h0) begin bad++; $display("FAIL reset_led: got %h want 0000", led); end
    total++;
    if (SDA !== 1'b1) begin bad++; $display("FAIL reset_sda: got %b want 1 (released)", SDA); end
    reset = 1'b0;
    wq(5);
  endtask

  task automatic test_good_packet();
    int r0 = rx_cnt;
    int c;
    tx_q = '{8'h24, 8'h01, 8'h2C, 8'h14};
    run_packet(1'b0);
    total++;
    if (is_receiving !== 1'b1) begin bad++; $display("FAIL t1_is_rx: got %b want 1", is_receiving); end
    stop_cond();
    c = model_commit(1'b1);
    for (int i = 0; i < ack_q.size(); i++) begin
      total++;
      if (ack_q[i] !== exp_ack(i)) begin bad++; $display("FAIL t1_ack[%0d]: got %b want %b", i, ack_q[i], exp_ack(i)); end
    end
    total++;
    if (is_receiving !== 1'b0) begin bad++; $display("FAIL t1_is_rx_stop: got %b want 0", is_receiving); end
    total++;
    if (ball_y !== 10'd300 || ball_vy !== 8'd20) begin bad++; $display("FAIL t1_ball: got y=%0d vy=%0d want y=300 vy=20", ball_y, ball_vy); end
    total++;
    if (rx_cnt - r0 !== c) begin bad++; $display("FAIL t1_rx_cycles: got %0d want %0d", rx_cnt - r0, c); end
  endtask

  task automatic test_wrong_addr();
    int r0 = rx_cnt;
    int l0 = slave_low;
    tx_q = '{8'h26, 8'($urandom), 8'($urandom), 8'($urandom)};
    run_packet(1'b1);
    total++;
    if (slave_low !== l0) begin bad++; $display("FAIL t2_sda_driven: got %0d low cycles want 0", slave_low - l0); end
    total++;
    if (rx_cnt !== r0 + model_commit(1'b1)) begin bad++; $display("FAIL t2_rx: got %0d want 0", rx_cnt - r0); end
    total++;
    if (ball_y !== exp_y || ball_vy !== exp_vy) begin bad++; $display("FAIL t2_hold: got y=%0d vy=%0d want y=%0d vy=%0d", ball_y, ball_vy, exp_y, exp_vy); end
  endtask

  task automatic test_read_addr();
    int r0 = rx_cnt;
    tx_q = '{8'h25};
    run_packet(1'b0);
    total++;
    if (ack_q[0] !== 1'b0) begin bad++; $display("FAIL t3_nack: got ack=%b want 0", ack_q[0]); end
    total++;
    if (led[15:12] !== 4'd5) begin bad++; $display("FAIL t3_state: got %0d want 5", led[15:12]); end
    stop_cond();
    total++;
    if (led[15:12] !== 4'd0) begin bad++; $display("FAIL t3_state_stop: got %0d want 0", led[15:12]); end
    total++;
    if (rx_cnt !== r0) begin bad++; $display("FAIL t3_rx: got %0d want 0", rx_cnt - r0); end
  endtask

  task automatic test_short_packet();
    int r0 = rx_cnt;
    int c;
    tx_q = '{8'h24, 8'($urandom), 8'($urandom)};
    run_packet(1'b1);
    c = model_commit(1'b1);
    for (int i = 0; i < ack_q.size(); i++) begin
      total++;
      if (ack_q[i] !== exp_ack(i)) begin bad++; $display("FAIL t4_ack[%0d]: got %b want %b", i, ack_q[i], exp_ack(i)); end
    end
    total++;
    if (rx_cnt - r0 !== c) begin bad++; $display("FAIL t4_rx: got %0d want %0d", rx_cnt - r0, c); end
    total++;
    if (ball_y !== exp_y || ball_vy !== exp_vy) begin bad++; $display("FAIL t4_hold: got y=%0d vy=%0d want y=%0d vy=%0d", ball_y, ball_vy, exp_y, exp_vy); end
  endtask

  task automatic test_restart();
    int r0 = rx_cnt;
    int c;
    tx_q = '{8'h24, 8'h03};
    run_packet(1'b0);
    c = model_commit(1'b0);
    tx_q = '{8'h24, 8'h02, 8'hFF, 8'h80};
    run_packet(1'b1);
    c += model_commit(1'b1);
    for (int i = 0; i < ack_q.size(); i++) begin
      total++;
      if (ack_q[i] !== exp_ack(i)) begin bad++; $display("FAIL t5_ack[%0d]: got %b want %b", i, ack_q[i], exp_ack(i)); end
    end
    total++;
    if (ball_y !== 10'd767 || ball_vy !== 8'd128) begin bad++; $display("FAIL t5_ball: got y=%0d vy=%0d want y=767 vy=128", ball_y, ball_vy); end
    total++;
    if (rx_cnt - r0 !== c) begin bad++; $display("FAIL t5_rx: got %0d want %0d", rx_cnt - r0, c); end
  endtask

  task automatic test_reset_mid_ack();
    bit a;
    int r0;
    int c;
    tx_q = '{8'h24};
    run_packet(1'b0);
    send_bits(8'h5A);
    m_sda_low = 1'b0; wq(Q);
    total++;
    if (SDA !== 1'b0 || led[15:12] !== 4'd4) begin bad++; $display("FAIL t6_ack_held: got sda=%b state=%0d want sda=0 state=4", SDA, led[15:12]); end
    reset = 1'b1;
    exp_y = 10'd0; exp_vy = 8'd0;
    wq(1);
    total++;
    if (SDA !== 1'b1) begin bad++; $display("FAIL t6_sda_release: got %b want 1", SDA); end
    total++;
    if ({ball_y, ball_vy, rx_valid, is_receiving, led} !== 36'd0) begin bad++; $display("FAIL t6_outputs: got y=%0d vy=%0d led=%h rx=%b isrx=%b want all 0", ball_y, ball_vy, led, rx_valid, is_receiving); end
    reset = 1'b0;
    scl = 1'b1; wq(Q);
    r0 = rx_cnt;
    tx_q = '{8'h24, 8'h01, 8'h2C, 8'h14};
    ack_q.delete();
    start_cond();
    foreach (tx_q[i]) begin send_byte(tx_q[i], a); ack_q.push_back(a); end
    stop_cond();
    c = model_commit(1'b1);
    for (int i = 0; i < ack_q.size(); i++) begin
      total++;
      if (ack_q[i] !== exp_ack(i)) begin bad++; $display("FAIL t6_ack[%0d]: got %b want %b", i, ack_q[i], exp_ack(i)); end
    end
    total++;
    if (ball_y !== exp_y || ball_vy !== exp_vy || rx_cnt - r0 !== c) begin bad++; $display("FAIL t6_after: got y=%0d vy=%0d rx=%0d want y=%0d vy=%0d rx=%0d", ball_y, ball_vy, rx_cnt - r0, exp_y, exp_vy, c); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      int r0 = rx_cnt;
      int n = $urandom_range(0, 4);
      int sel = $urandom_range(0, 3);
      int c;
      tx_q.delete();
      tx_q.push_back(sel < 2 ? 8'h24 : (sel == 2 ? 8'h26 : 8'($urandom)));
      for (int j = 0; j < n; j++) tx_q.push_back(8'($urandom));
      run_packet(1'b1);
      c = model_commit(1'b1);
      for (int i = 0; i < ack_q.size(); i++) begin
        total++;
        if (ack_q[i] !== exp_ack(i)) begin bad++; $display("FAIL rnd%0d_ack[%0d]: got %b want %b", k, i, ack_q[i], exp_ack(i)); end
      end
      total++;
      if (ball_y !== exp_y || ball_vy !== exp_vy || rx_cnt - r0 !== c) begin bad++; $display("FAIL rnd%0d_out: got y=%0d vy=%0d rx=%0d want y=%0d vy=%0d rx=%0d", k, ball_y, ball_vy, rx_cnt - r0, exp_y, exp_vy, c); end
    end
  endtask

  initial begin
    test_reset();
    test_good_packet();
    test_wrong_addr();
    test_read_addr();
    test_short_packet();
    test_restart();
    test_reset_mid_ack();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
